reg_file_rd_ctrl: RTL
=====================

Name: reg_file_rd_ctrl

Overview:
- Read-side controller for the flat-output register file (one write port, all registers presented on one packed bus).
- Accepts single or burst read requests over a valid/ready handshake.
- Selects words from the packed bus and returns them as registered response beats, with a second valid/ready handshake and backpressure.
- Sits between the register file and any consumer that reads registers, e.g. a debug or formal harness.

Parameters:
- DATA_W, 16, width of one register
- NUM_REGS, 2, number of registers on the packed bus
- ADDR_W, 3, request address width; must satisfy 2**ADDR_W >= NUM_REGS

Ports:
- clock  input  1  single clock; all logic on the rising edge
- reset  input  1  synchronous, active-high reset
- regs_in  input  DATA_W*NUM_REGS  packed register bus; register i occupies bits [DATA_W*(NUM_REGS-1-i) +: DATA_W], so register 0 is in the MSB slice
- req_valid  input  1  request present
- req_ready  output  1  request accepted when req_valid && req_ready
- req_addr  input  ADDR_W  start register index
- req_burst  input  1  0 = single read; 1 = read req_addr .. NUM_REGS-1
- rsp_valid  output  1  response beat present
- rsp_ready  input  1  beat consumed when rsp_valid && rsp_ready
- rsp_data  output  DATA_W  register contents
- rsp_addr  output  ADDR_W  index of the returned register
- rsp_last  output  1  final beat of the request
- rsp_err  output  1  request address >= NUM_REGS
- busy  output  1  high while in STREAM or while rsp_valid=1

Behaviour:
- Reset (synchronous, active-high): state=IDLE; rsp_valid, rsp_data, rsp_addr, rsp_last, rsp_err and busy all 0. req_ready is 0 while reset is high.
- Reset mid-burst aborts the burst. No further beats are produced, and a pending beat is dropped.
- Output slot: a single response register. The slot is "free" when rsp_valid=0 or (rsp_valid && rsp_ready).
- States:
  - IDLE: req_ready = slot free.
  - STREAM: req_ready = 0. Holds the next index ptr.
- Accept in IDLE (req_valid && req_ready), edge-sampled:
  - If req_addr >= NUM_REGS: load the beat {data=0, addr=req_addr, err=1, last=1}. Stay in IDLE. This applies regardless of req_burst.
  - Else if req_burst=0, or req_addr == NUM_REGS-1: load {data=reg[req_addr], addr=req_addr, err=0, last=1}. Stay in IDLE.
  - Else (burst): load {reg[req_addr], req_addr, 0, last=0}. Set ptr=req_addr+1 and go to STREAM.
- STREAM, on each edge where the slot is free:
  - Load {reg[ptr], ptr, 0, last=(ptr==NUM_REGS-1)}.
  - If last: go to IDLE. Else: ptr=ptr+1.
- Latency: the response beat is valid one cycle after the accept edge.
- Throughput: one beat per cycle while rsp_ready is held high. A new request can be accepted in the same cycle the final beat is consumed (back-to-back).
- Data sampling: regs_in is sampled at the edge on which the beat is loaded.
  - A register-file write that lands before a beat's load edge is visible in that beat.
  - Once loaded, the beat is frozen.
- Backpressure: while rsp_valid && !rsp_ready, all rsp_* outputs hold stable. No state or ptr advance occurs.
- Slot clearing: when the slot is consumed and nothing new is loaded, rsp_valid goes to 0 on the next edge. Other rsp_* outputs may hold their last values.
- req_* inputs are ignored whenever req_ready=0.
- ptr never exceeds NUM_REGS-1. There is no wrap-around; a burst always ends at NUM_REGS-1.

Test Plan:
1. Single read. regs_in=32'hA5A5_5A5A, rsp_ready=1; request addr=1, burst=0.
   -> Next cycle: rsp_valid=1, data=16'h5A5A, addr=1, last=1, err=0. Following cycle: rsp_valid=0.
2. Burst read. Same regs; request addr=0, burst=1, rsp_ready=1.
   -> Beat 1: data=16'hA5A5, addr=0, last=0. Beat 2: data=16'h5A5A, addr=1, last=1. req_ready=0 during the burst.
3. Backpressure. Burst from 0 with rsp_ready=0 for 3 cycles, then 1.
   -> Beat 0 is held unchanged for 3 cycles, then beats 0 and 1 complete in order. Change regs_in[15:0] to 16'h1234 during the stall: beat 1 returns 16'h1234.
4. Error. Request addr=5 with burst=1.
   -> One beat: data=0, addr=5, err=1, last=1. Controller stays IDLE and req_ready returns to 1.
5. Reset mid-burst. Assert reset while beat 0 of a burst is stalled.
   -> Next cycle: rsp_valid=0, busy=0, state IDLE. No beat 1 after reset deasserts.
6. Back-to-back. rsp_ready=1; a single read of addr=0 immediately follows a completed burst.
   -> Request accepted on the cycle the last beat is consumed. Beat with data=16'hA5A5 appears with no bubble.

Source files
------------

// File: rtl/reg_file_rd_ctrl.sv
// reg_file_rd_ctrl: single/burst read controller over a packed register bus with a registered response slot
module reg_file_rd_ctrl #(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 2,
  parameter int ADDR_W   = 3
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [DATA_W*NUM_REGS-1:0] regs_in,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [ADDR_W-1:0]          req_addr,
  input  logic                       req_burst,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [DATA_W-1:0]          rsp_data,
  output logic [ADDR_W-1:0]          rsp_addr,
  output logic                       rsp_last,
  output logic                       rsp_err,
  output logic                       busy
);
  typedef enum logic {IDLE, STREAM} state_t;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_REGS - 1);
  state_t            state;
  logic [ADDR_W-1:0] ptr;
  logic [DATA_W-1:0] regs [2**ADDR_W];
  logic              slot_free, accept, advance, bad, single;
  // register 0 lives in the MSB slice; unused address slots read as zero
  for (genvar i = 0; i < 2**ADDR_W; i++) begin : g_reg
    if (i < NUM_REGS) begin : g_on
      assign regs[i] = regs_in[DATA_W*(NUM_REGS-1-i) +: DATA_W];
    end else begin : g_off
      assign regs[i] = '0;
    end
  end
  assign slot_free = !rsp_valid || rsp_ready;
  assign req_ready = !reset && state == IDLE && slot_free;
  assign accept    = req_valid && req_ready;
  assign advance   = state == STREAM && slot_free;
  assign bad       = req_addr > LAST;
  assign single    = !req_burst || req_addr == LAST;
  assign busy      = state == STREAM || rsp_valid;
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      ptr       <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_addr  <= '0;
      rsp_last  <= 1'b0;
      rsp_err   <= 1'b0;
    end else if (accept) begin
      rsp_valid <= 1'b1;
      rsp_data  <= bad ? '0 : regs[req_addr];
      rsp_addr  <= req_addr;
      rsp_err   <= bad;
      rsp_last  <= bad || single;
      if (!bad && !single) begin
        state <= STREAM;
        ptr   <= req_addr + 1'b1;
      end
    end else if (advance) begin
      rsp_valid <= 1'b1;
      rsp_data  <= regs[ptr];
      rsp_addr  <= ptr;
      rsp_err   <= 1'b0;
      rsp_last  <= ptr == LAST;
      if (ptr == LAST) state <= IDLE;
      else ptr <= ptr + 1'b1;
    end else if (slot_free) begin
      rsp_valid <= 1'b0;
    end
  end
endmodule
